// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage access unit and its lane aligner.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE   = 2'd0,
        MEM_SIZE_HALF   = 2'd1,
        MEM_SIZE_WORD   = 2'd2,
        MEM_SIZE_DOUBLE = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int sel_width(input int data_width);
        return data_width / 8;
    endfunction

    // offset is the byte offset within the RAM word; wide is set for 64-bit RAMs.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset,
                                           input logic wide);
        case (mem_size_t'(size))
            MEM_SIZE_BYTE: return 1'b0;
            MEM_SIZE_HALF: return offset[0];
            MEM_SIZE_WORD: return |offset[1:0];
            default:       return !wide || (|offset);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane shifter: store mask/data placement and load extract/extend.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = sel_width(DATA_WIDTH)
) (
    input  logic [1:0]                   size,
    input  logic                         sign_ext,
    input  logic [$clog2(SEL_WIDTH)-1:0] offset,
    input  logic [DATA_WIDTH-1:0]        store_data,
    input  logic [DATA_WIDTH-1:0]        load_word,
    output logic [SEL_WIDTH-1:0]         lane_mask,
    output logic [DATA_WIDTH-1:0]        lane_data,
    output logic [DATA_WIDTH-1:0]        load_data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep;
    logic                  sign;
    int unsigned           nbits;

    always_comb begin
        lane_mask = SEL_WIDTH'((32'd1 << (32'd1 << size)) - 32'd1) << offset;
        lane_data = store_data << {offset, 3'b000};

        nbits = 32'd8 << size;
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        shifted = load_word >> {offset, 3'b000};
        // keep covers the loaded bits; everything above is filled with the extension bit
        keep    = ~({DATA_WIDTH{1'b1}} << nbits);
        sign    = sign_ext & (|(shifted & (DATA_WIDTH'(1) << (nbits - 1))));
        load_data = (shifted & keep) | ({DATA_WIDTH{sign}} & ~keep);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage RAM driver: enable/ack handshake, timeout watchdog, pipeline stall.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = sel_width(DATA_WIDTH),
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic                  req_sign_ext,
    input  logic [1:0]            req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ram_en,
    output logic [SEL_WIDTH-1:0]  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    input  logic                  ram_ack,
    output logic                  stall_req,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  addr_error,
    output logic                  bus_error
);

    localparam int OFF_WIDTH = $clog2(SEL_WIDTH);
    localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);

    state_t                 state;
    logic [1:0]             size_q;
    logic [OFF_WIDTH-1:0]   off_q;
    logic                   sign_q;
    logic                   write_q;
    logic [CNT_WIDTH-1:0]   cnt;

    logic [OFF_WIDTH-1:0]   req_off;
    logic                   misaligned;
    logic [1:0]             align_size;
    logic [OFF_WIDTH-1:0]   align_off;
    logic [SEL_WIDTH-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0]  lane_data;
    logic [DATA_WIDTH-1:0]  load_data;

    assign req_off = req_addr[OFF_WIDTH-1:0];

    // The aligner serves the incoming request while IDLE and the latched one afterwards.
    always_comb begin
        misaligned = is_misaligned(req_size, 3'(req_off), DATA_WIDTH == 64);
        align_size = (state == IDLE) ? req_size : size_q;
        align_off  = (state == IDLE) ? req_off  : off_q;
        stall_req  = (state == BUSY) || (state == IDLE && req_valid && !misaligned);
    end

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_align (
        .size       (align_size),
        .sign_ext   (sign_q),
        .offset     (align_off),
        .store_data (req_wdata),
        .load_word  (ram_read_data),
        .lane_mask  (lane_mask),
        .lane_data  (lane_data),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            size_q         <= '0;
            off_q          <= '0;
            sign_q         <= 1'b0;
            write_q        <= 1'b0;
            cnt            <= '0;
            ram_en         <= 1'b0;
            ram_write_en   <= '0;
            ram_addr       <= '0;
            ram_write_data <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            addr_error     <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && misaligned) begin
                        addr_error <= 1'b1;
                    end else if (req_valid) begin
                        state          <= BUSY;
                        cnt            <= '0;
                        size_q         <= req_size;
                        off_q          <= req_off;
                        sign_q         <= req_sign_ext;
                        write_q        <= req_write;
                        ram_en         <= 1'b1;
                        ram_addr       <= {req_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                        ram_write_en   <= req_write ? lane_mask : '0;
                        ram_write_data <= req_write ? lane_data : '0;
                    end
                end
                BUSY: begin
                    if (ram_ack || cnt == CNT_WIDTH'(MAX_WAIT - 1)) begin
                        state          <= DONE;
                        resp_valid     <= 1'b1;
                        bus_error      <= !ram_ack;
                        resp_data      <= (ram_ack && !write_q) ? load_data : '0;
                        ram_en         <= 1'b0;
                        ram_write_en   <= '0;
                        ram_write_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised, multi-cycle successor to the combinational MEM-stage RAM driver.
- Accepts one load/store per request from the EX/MEM pipeline register.
- Drives a RAM port with an enable/acknowledge handshake and an access-timeout watchdog.
- Aligns store data onto byte lanes, extracts and extends load data, flags misaligned accesses, and stalls the pipeline while an access is outstanding.

Parameters:
- DATA_WIDTH, 32: RAM word width in bits; legal values 32 or 64.
- ADDR_WIDTH, 32: byte-address width.
- SEL_WIDTH, DATA_WIDTH/8: byte-lane count.
- MAX_WAIT, 15: BUSY cycles allowed without ram_ack before a bus error; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  a memory request is present
- req_write  in  1  1 = store, 0 = load
- req_sign_ext  in  1  sign-extend load data
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_WIDTH = 64)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- ram_en  out  1  RAM access strobe
- ram_write_en  out  SEL_WIDTH  byte-lane write enables
- ram_addr  out  ADDR_WIDTH  word-aligned address
- ram_write_data  out  DATA_WIDTH  lane-shifted store data
- ram_read_data  in  DATA_WIDTH  RAM read word
- ram_ack  in  1  access complete; ram_read_data valid in the same cycle
- stall_req  out  1  pipeline must hold
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores
- addr_error  out  1  one-cycle misalignment pulse
- bus_error  out  1  one-cycle timeout pulse

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE.
  - All registered outputs = 0: ram_en, ram_write_en, ram_addr, ram_write_data, resp_valid, resp_data, addr_error, bus_error.
  - Wait counter = 0.
- Reset mid-access: abandons the access; any later ram_ack is ignored while in IDLE.
- Request decode in IDLE:
  - offset = req_addr[log2(SEL_WIDTH)-1:0].
  - Misaligned if any of:
    - half with odd offset;
    - word with offset not a multiple of 4;
    - double with offset != 0;
    - size 3 when DATA_WIDTH = 32.
- State machine, IDLE -> BUSY -> DONE -> IDLE:
  - IDLE, req_valid and aligned: register the request, go to BUSY. stall_req = 1 combinationally this cycle.
  - IDLE, req_valid and misaligned: no RAM access. addr_error pulses in the next cycle. Stay IDLE. stall_req = 0.
  - BUSY:
    - Drive ram_en = 1 and ram_addr = {addr[ADDR_WIDTH-1:log2 SEL_WIDTH], zeros}.
    - For stores only: ram_write_en = size mask << offset, ram_write_data = req_wdata << (8*offset). Size masks are 1, 3, 0xF, 0xFF.
    - stall_req = 1. The wait counter increments each cycle.
  - BUSY, ram_ack: capture load data (ram_read_data >> 8*offset), truncate to size, then sign- or zero-extend per req_sign_ext. Go to DONE. ram_en drops at that edge.
  - BUSY, counter reaches MAX_WAIT without ram_ack: bus_error pulses, go to DONE with resp_data = 0.
  - DONE:
    - resp_valid = 1 for exactly one cycle; stall_req = 0.
    - req_valid is ignored, because it still holds the completed instruction. Return to IDLE.
- Simultaneous events: ram_ack in the same cycle the counter hits MAX_WAIT counts as a success; no bus_error.
- Latency: the minimum load/store is 3 cycles from acceptance to resp_valid (ack in the first BUSY cycle). Back-to-back requests are spaced at least 3 cycles apart.
- ram_write_en is always 0 for loads.

Decomposition:
- Shared package/header:
  - size encodings MEM_SIZE_BYTE/HALF/WORD/DOUBLE;
  - state encodings IDLE/BUSY/DONE;
  - SEL_WIDTH derivation.
- Sub-module mem_lane_align: combinational store lane shift/mask and load extract/extend, parametrised by DATA_WIDTH. It is reused by a future cache fill path.

Test Plan:
- Byte store at addr 0x1003, wdata 0xAB, ack after 2 BUSY cycles -> ram_addr 0x1000, ram_write_en 0b1000, ram_write_data 0xAB000000, resp_valid in cycle 4, stall_req high for cycles 1-3.
- Signed half load at 0x2002, ram_read_data 0x80010000, immediate ack -> resp_data 0xFFFF8001. Same with req_sign_ext = 0 -> 0x00008001.
- Word load at 0x3001 -> addr_error pulse in the next cycle, ram_en never asserted, stall_req low, no resp_valid.
- Store with ram_ack withheld, MAX_WAIT = 15 -> bus_error after 15 BUSY cycles, then resp_valid, ram_en low afterwards.
- rst asserted during BUSY, then ram_ack arrives -> state IDLE, all outputs 0, no resp_valid. The next request is accepted normally.
- DATA_WIDTH = 64 build: double store at 0x08 -> ram_write_en 0xFF. Double store at 0x04 -> addr_error. DATA_WIDTH = 32 build, any size 3 -> addr_error.
